// File: rtl/brlite_svc_queue_pkg.sv
// Shared types for the BrLite service-receive path: the service message
// layout, the default queue depth and the handshake FSM states.
package brlite_svc_queue_pkg;

    typedef struct packed {
        logic [7:0]  ksvc;
        logic [15:0] seq_source;
        logic [15:0] producer;
        logic [31:0] payload;
    } brlite_svc_t;

    localparam int BRLITE_SVC_QUEUE_DEPTH = 8;

    typedef enum logic [1:0] {
        SVCQ_IDLE,
        SVCQ_ACK,
        SVCQ_WAIT
    } svcq_state_t;

endpackage

// File: rtl/brlite_fifo.sv
// Generic DEPTH-entry FIFO of service messages with wrap-around pointers
// and an occupancy count; a push when full or a pop when empty is ignored.
module brlite_fifo
    import brlite_svc_queue_pkg::*;
#(
    parameter  int DEPTH = BRLITE_SVC_QUEUE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  brlite_svc_t       wdata_i,
    output brlite_svc_t       rdata_o,
    output logic [CNT_W-1:0]  count_o
);

    brlite_svc_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push_i && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = pop_i  && (r_count != '0);

    // Storage is not reset; its contents are irrelevant while the count is zero.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata_o = r_mem[r_rptr];
    assign count_o = r_count;

endmodule

// File: rtl/brlite_svc_queue.sv
// Receive-side buffer between the BrLite router local port and the NI:
// req/ack capture FSM in front of a service-message FIFO.
module brlite_svc_queue
    import brlite_svc_queue_pkg::*;
#(
    parameter  int DEPTH = BRLITE_SVC_QUEUE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              br_req_i,
    output logic              br_ack_o,
    input  brlite_svc_t       br_data_i,
    output logic              br_svc_rx_o,
    input  logic              br_svc_ack_i,
    output brlite_svc_t       br_svc_data_o,
    output logic [CNT_W-1:0]  occupancy_o,
    output logic              stall_o
);

    svcq_state_t      r_state;
    svcq_state_t      w_next_state;
    logic             w_push;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    brlite_svc_t      w_head;

    assign w_full = (w_count == CNT_W'(DEPTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SVCQ_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // WAIT holds off until req drops so a late-dropping router gets one capture.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SVCQ_IDLE: if (br_req_i && !w_full) w_next_state = SVCQ_ACK;
            SVCQ_ACK:  w_next_state = SVCQ_WAIT;
            SVCQ_WAIT: if (!br_req_i) w_next_state = SVCQ_IDLE;
            default:   w_next_state = SVCQ_IDLE;
        endcase
    end

    always_comb begin
        br_ack_o = (r_state == SVCQ_ACK);
        w_push   = (r_state == SVCQ_IDLE) && br_req_i && !w_full;
        stall_o  = (r_state == SVCQ_IDLE) && br_req_i && w_full;
    end

    brlite_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (br_svc_ack_i),
        .wdata_i (br_data_i),
        .rdata_o (w_head),
        .count_o (w_count)
    );

    assign occupancy_o   = w_count;
    assign br_svc_rx_o   = (w_count != '0);
    assign br_svc_data_o = br_svc_rx_o ? w_head : '0;

endmodule
